// File: rtl/req_enc_pkg.sv
// Shared widths and FSM state type for the 8-to-3 request encoder.
package req_enc_pkg;

    localparam int unsigned DEF_IDX_W = 3;
    localparam int unsigned DEF_N     = 1 << DEF_IDX_W;

    typedef enum logic [0:0] {
        ST_EMPTY,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/prio_enc8.sv
// Combinational priority encoder: reports the highest set index of pending.
module prio_enc8
    import req_enc_pkg::*;
#(
    parameter int unsigned IDX_W = DEF_IDX_W,
    localparam int unsigned N    = 1 << IDX_W
) (
    input  logic [N-1:0]     pending,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (pending[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_encoder8_to_3.sv
// Sticky request collector that grants the highest pending index over a
// valid/ready port, one index per accepted transfer.
module req_encoder8_to_3
    import req_enc_pkg::*;
#(
    parameter int unsigned IDX_W = DEF_IDX_W,
    localparam int unsigned N    = 1 << IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     out_onehot,
    input  logic             ovf_clr,
    output logic             overflow,
    output logic [N-1:0]     pending
);

    state_e           state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [N-1:0]     out_onehot_q, out_onehot_d;
    logic             overflow_q, overflow_d;

    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;
    logic             load;
    logic [N-1:0]     grant;

    prio_enc8 #(
        .IDX_W (IDX_W)
    ) u_prio_enc8 (
        .pending (pending_q),
        .idx     (sel_idx),
        .any     (sel_any)
    );

    always_comb begin
        load         = 1'b0;
        state_d      = state_q;
        out_idx_d    = out_idx_q;
        out_onehot_d = out_onehot_q;

        unique case (state_q)
            ST_EMPTY: load = sel_any;
            ST_HOLD:  load = sel_any && out_ready;
            default:  load = 1'b0;
        endcase

        grant = load ? (N'(1) << sel_idx) : '0;

        if (load) begin
            state_d      = ST_HOLD;
            out_idx_d    = sel_idx;
            out_onehot_d = grant;
        end else if (state_q == ST_HOLD && out_ready) begin
            // Drained: index keeps its last value, one-hot echo goes quiet.
            state_d      = ST_EMPTY;
            out_onehot_d = '0;
        end

        // A req on the bit being granted re-arms it as a new event.
        pending_d  = (pending_q & ~grant) | req;
        overflow_d = (|(req & pending_q & ~grant)) | (overflow_q & ~ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            pending_q    <= '0;
            out_idx_q    <= '0;
            out_onehot_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            out_idx_q    <= out_idx_d;
            out_onehot_q <= out_onehot_d;
            overflow_q   <= overflow_d;
        end
    end

    assign out_valid  = (state_q == ST_HOLD);
    assign out_idx    = out_idx_q;
    assign out_onehot = out_onehot_q;
    assign overflow   = overflow_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_req_encoder8_to_3.sv
// Self-checking bench: directed scenarios plus random traffic against an
// event-list reference model of the request encoder.
module tb_req_encoder8_to_3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_idx;
    logic [7:0] out_onehot;
    logic       ovf_clr;
    logic       overflow;
    logic [7:0] pending;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: per-line pending flags, held grant, overflow.
    bit m_pend[8];
    bit m_valid;
    int m_idx;
    bit m_ovf;

    req_encoder8_to_3 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .ovf_clr    (ovf_clr),
        .overflow   (overflow),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic [7:0] r, input logic rdy, input logic clr,
                              input logic rst);
        int  sel;
        int  g;
        bit  lost;
        if (!rst) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_valid = 1'b0;
            m_idx   = 0;
            m_ovf   = 1'b0;
        end else begin
            sel = -1;
            for (int i = 7; i >= 0; i--) if (sel < 0 && m_pend[i]) sel = i;
            g = (sel >= 0 && (!m_valid || rdy)) ? sel : -1;
            lost = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (r[i] && m_pend[i] && i != g) lost = 1'b1;
                if (r[i]) m_pend[i] = 1'b1;
                else if (i == g) m_pend[i] = 1'b0;
            end
            if (g >= 0) begin
                m_valid = 1'b1;
                m_idx   = g;
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            m_ovf = lost ? 1'b1 : (clr ? 1'b0 : m_ovf);
        end
    endtask

    task automatic cyc(input logic [7:0] r, input logic rdy, input logic clr, input logic rst);
        logic [7:0] exp_pend;
        req       = r;
        out_ready = rdy;
        ovf_clr   = clr;
        rst_n     = rst;
        @(posedge clk);
        #1;
        model_step(r, rdy, clr, rst);
        for (int i = 0; i < 8; i++) exp_pend[i] = m_pend[i];
        check_val("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        check_val("out_idx", {29'b0, out_idx}, m_idx);
        check_val("out_onehot", {24'b0, out_onehot}, m_valid ? (32'd1 << m_idx) : 32'd0);
        check_val("pending", {24'b0, pending}, {24'b0, exp_pend});
        check_val("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    endtask

    initial begin
        req = '0; out_ready = 1'b0; ovf_clr = 1'b0; rst_n = 1'b0;

        // Reset with all requests asserted.
        cyc(8'hFF, 1'b1, 1'b0, 1'b0);
        cyc(8'hFF, 1'b1, 1'b0, 1'b0);
        check_val("rst_pending", {24'b0, pending}, 32'h0);
        check_val("rst_valid", {31'b0, out_valid}, 32'h0);
        repeat (3) cyc(8'h00, 1'b1, 1'b0, 1'b1);
        check_val("idle_valid", {31'b0, out_valid}, 32'h0);

        // Single request: valid for exactly one cycle, two edges later.
        cyc(8'h04, 1'b1, 1'b0, 1'b1);
        check_val("single_early", {31'b0, out_valid}, 32'h0);
        cyc(8'h00, 1'b1, 1'b0, 1'b1);
        check_val("single_idx", {29'b0, out_idx}, 32'd2);
        check_val("single_onehot", {24'b0, out_onehot}, 32'h04);
        cyc(8'h00, 1'b1, 1'b0, 1'b1);
        check_val("single_done", {31'b0, out_valid}, 32'h0);

        // Priority drain 7, 4, 1.
        cyc(8'h92, 1'b1, 1'b0, 1'b1);
        cyc(8'h00, 1'b1, 1'b0, 1'b1);
        check_val("drain_7", {29'b0, out_idx}, 32'd7);
        cyc(8'h00, 1'b1, 1'b0, 1'b1);
        check_val("drain_4", {29'b0, out_idx}, 32'd4);
        cyc(8'h00, 1'b1, 1'b0, 1'b1);
        check_val("drain_1", {29'b0, out_idx}, 32'd1);
        cyc(8'h00, 1'b1, 1'b0, 1'b1);
        check_val("drain_empty", {31'b0, out_valid}, 32'h0);

        // Backpressure.
        cyc(8'h81, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cyc(8'h00, 1'b0, 1'b0, 1'b1);
            check_val("bp_hold_idx", {29'b0, out_idx}, 32'd7);
            check_val("bp_pending", {24'b0, pending}, 32'h01);
        end
        cyc(8'h00, 1'b1, 1'b0, 1'b1);
        check_val("bp_next_idx", {29'b0, out_idx}, 32'd0);
        check_val("bp_next_valid", {31'b0, out_valid}, 32'h1);
        cyc(8'h00, 1'b1, 1'b0, 1'b1);

        // Overflow set, set-beats-clear, then clear.
        cyc(8'h20, 1'b0, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        check_val("ovf_hold5", {29'b0, out_idx}, 32'd5);
        cyc(8'h08, 1'b0, 1'b0, 1'b1);
        check_val("ovf_first", {31'b0, overflow}, 32'h0);
        cyc(8'h08, 1'b0, 1'b0, 1'b1);
        check_val("ovf_set", {31'b0, overflow}, 32'h1);
        cyc(8'h08, 1'b0, 1'b1, 1'b1);
        check_val("ovf_set_wins", {31'b0, overflow}, 32'h1);
        cyc(8'h00, 1'b0, 1'b1, 1'b1);
        check_val("ovf_cleared", {31'b0, overflow}, 32'h0);
        cyc(8'h00, 1'b1, 1'b0, 1'b1);
        cyc(8'h00, 1'b1, 1'b0, 1'b1);

        // Re-request of the held index is a new event, not an overflow.
        cyc(8'h40, 1'b0, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        cyc(8'h40, 1'b0, 1'b0, 1'b1);
        check_val("rereq_ovf", {31'b0, overflow}, 32'h0);
        check_val("rereq_pend", {24'b0, pending}, 32'h40);
        cyc(8'h00, 1'b1, 1'b0, 1'b1);
        check_val("rereq_idx", {29'b0, out_idx}, 32'd6);
        check_val("rereq_valid", {31'b0, out_valid}, 32'h1);
        cyc(8'h00, 1'b1, 1'b0, 1'b1);
        check_val("rereq_done", {31'b0, out_valid}, 32'h0);

        // Random traffic, occasional mid-run reset.
        for (int k = 0; k < 3000; k++) begin
            logic [7:0] r;
            r = 8'($urandom) & 8'($urandom) & 8'($urandom);
            cyc(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 199) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
